// File: rtl/red_seq_ctrl.sv
// Byte-pair reduction sequencer: one shared 9-bit adder, 4 cycles start-to-done, ignores start while busy.
// Optional RED_SEQ_ABORT_EN adds an abort input that drops an in-flight sequence back to IDLE.
module red_seq_ctrl #(
  parameter int SEXT_BIT = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef RED_SEQ_ABORT_EN
  input  logic        abort,
`endif
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] Sum,
  output logic        Error
);

  typedef enum logic [2:0] {IDLE, S_AC, S_BD, S_FIN, DONE} state_t;

  state_t      state;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [8:0]  ac;
  logic [8:0]  bd;
  logic [8:0]  add_a;
  logic [8:0]  add_b;
  logic [9:0]  add_sum;
  logic [11:0] tmp;
  logic [15:0] sext_val;
  logic        carry3;
  logic        carry7;
  logic        abort_req;

`ifdef RED_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The single adder; operands steered by state, zero-extended in the byte phases.
  always_comb begin
    add_a = 9'd0;
    add_b = 9'd0;
    case (state)
      S_AC:    begin add_a = {1'b0, op_a[15:8]}; add_b = {1'b0, op_b[15:8]}; end
      S_BD:    begin add_a = {1'b0, op_a[7:0]};  add_b = {1'b0, op_b[7:0]};  end
      S_FIN:   begin add_a = ac;                 add_b = bd;                 end
      default: begin add_a = 9'd0;               add_b = 9'd0;               end
    endcase
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b};
  assign tmp     = {2'b00, add_sum};

  // Carry into bit i+1 recovered from sum ^ a ^ b, so no second adder is needed.
  assign carry3 = add_sum[4] ^ ac[4] ^ bd[4];
  assign carry7 = add_sum[8] ^ ac[8] ^ bd[8];

  assign sext_val = tmp[SEXT_BIT] ? (({16{1'b1}} << SEXT_BIT) | {4'b0000, tmp})
                                  : {4'b0000, tmp};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= 16'h0000;
      Error <= 1'b0;
      op_a  <= 16'h0000;
      op_b  <= 16'h0000;
      ac    <= 9'd0;
      bd    <= 9'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= A;
            op_b  <= B;
            state <= S_AC;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        S_AC: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ac    <= add_sum[8:0];
            state <= S_BD;
          end
        end
        S_BD: begin
          if (abort_req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            bd    <= add_sum[8:0];
            state <= S_FIN;
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          if (abort_req) begin
            state <= IDLE;
          end else begin
            Sum   <= sext_val;
            Error <= carry3 | carry7;
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/red_seq_ctrl.md
Name: red_seq_ctrl

Overview:
Multi-cycle sequencer that computes the RED (byte-pair reduction) result using a single shared 9-bit adder instead of five parallel CLAs. It sits beside the ALU as an area-reduced RED path. The pipeline control issues it a start pulse and stalls on busy until done. Its results are bit-identical to the combinational RED unit.

Parameters:
SEXT_BIT, 9, index of the tmp-sum bit replicated into Sum[15:SEXT_BIT+1]. Legal range 9..11.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only when busy=0
A  input  16  operand A; latched on accepted start
B  input  16  operand B; latched on accepted start
busy  output  1  high in S_AC, S_BD, S_FIN
done  output  1  one-cycle pulse; Sum/Error valid
Sum  output  16  registered sign-extended reduction result
Error  output  1  registered overflow flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, any state): state=IDLE; busy=0, done=0, Sum=16'h0000, Error=0; all internal operand and partial registers are cleared.
- States: IDLE, S_AC, S_BD, S_FIN, DONE. Each non-IDLE state lasts exactly one cycle.
- IDLE:
  - start=1 latches A and B into opA and opB, then goes to S_AC.
  - start=0 stays in IDLE.
- S_AC: shared adder computes ac[8:0] = {0,opA[15:8]} + {0,opB[15:8]}. Register ac, go to S_BD.
- S_BD: shared adder computes bd[8:0] = {0,opA[7:0]} + {0,opB[7:0]}. Register bd, go to S_FIN.
- S_FIN: shared adder computes tmp[9:0] = ac + bd, unsigned. Go to DONE. On the same edge:
  - Sum <= {(15-SEXT_BIT){tmp[SEXT_BIT]}, tmp[SEXT_BIT:0]}.
  - Error <= carry out of bit 3 OR carry out of bit 7 of ac[7:0]+bd[7:0].
- DONE:
  - done=1 and busy=0.
  - start=1 is accepted: latch operands, go to S_AC (back-to-back issue).
  - start=0 goes to IDLE.
- Latency: start sampled at edge e0 gives done=1 in the cycle after edge e3, i.e. 4 cycles from request to result.
- Throughput: one result every 4 cycles.
- Sum and Error hold their value until the next S_FIN edge or reset. They do not change in IDLE.
- start while busy=1 is ignored. Operands are not re-latched and the in-flight result is unaffected.
- A and B are don't-care except on the accepting edge.
- Exactly one adder instance exists. Its inputs are muxed by state, with zero-extension in S_AC and S_BD.

Optional Feature:
RED_SEQ_ABORT_EN
- Defined:
  - Adds input port abort (1 bit, placed after start).
  - abort=1 in S_AC, S_BD or S_FIN forces state to IDLE on the next edge. No done pulse is produced, and Sum/Error keep their previous values.
  - abort has priority over the S_FIN result update.
  - abort in IDLE or DONE has no effect. In DONE, a simultaneous start is still accepted.
- Undefined: the port is absent and the sequence always runs to completion.

Test Plan:
- A=16'h1234, B=16'h0101, start 1 cycle -> busy high for 3 cycles; done pulse 4 cycles after start; Sum=16'h0048, Error=0.
- A=16'h7F7F, B=16'h0101 -> Sum=16'h0100, Error=1 (carry out of bit 7).
- A=16'hFFFF, B=16'hFFFF -> Sum=16'hFFFC (tmp=10'h3FC, bit 9 set), Error=1.
- Issue A=16'h1234, B=16'h0101; pulse start again in S_AC with A=16'hFFFF, B=16'hFFFF -> second start ignored; single done; Sum=16'h0048.
- Back-to-back: start asserted during DONE with A=B=16'h0000 -> no IDLE cycle; next done 4 cycles later with Sum=16'h0000, Error=0.
- Assert rst during S_BD -> busy, done, Error, Sum all 0 immediately (asynchronously); stays in IDLE after rst deasserts until the next start.
